// File: rtl/mole_spawner.sv
// rtl/mole_spawner.sv - whack-a-mole spawner: random hole and gap selection, up-window timing, hit/miss tallies
module mole_spawner #(
  parameter int N_HOLES  = 8,
  parameter int GAP_BASE = 4,
  parameter int UP_TICKS = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               enable,
  input  logic [7:0]         rnd,
  input  logic [N_HOLES-1:0] hit,
  output logic [N_HOLES-1:0] mole,
  output logic [7:0]         score,
  output logic [7:0]         misses,
  output logic               hit_pulse,
  output logic               miss_pulse
);

  localparam int HB = $clog2(N_HOLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_UP} state_t;

  state_t             state, state_d;
  logic [7:0]         cnt, cnt_d;
  logic [HB-1:0]      last_hole, last_hole_d;
  logic [N_HOLES-1:0] mole_d;
  logic [7:0]         score_d, misses_d;
  logic               hit_pulse_d, miss_pulse_d;

  logic [7:0]         gap_load;
  logic [HB-1:0]      rnd_idx, spawn_idx;
  logic               lit_hit, up_timeout, wait_done;
  logic               unused_rnd;

  assign gap_load   = 8'(GAP_BASE) + {5'd0, rnd[7:5]};
  assign rnd_idx    = rnd[HB-1:0];
  // Never light the same hole twice in a row.
  assign spawn_idx  = (rnd_idx == last_hole) ? rnd_idx + HB'(1) : rnd_idx;
  assign lit_hit    = hit[last_hole];
  assign up_timeout = tick && (cnt == 8'd1);
  assign wait_done  = tick && (cnt == 8'd1);
  assign unused_rnd = ^rnd[4:HB];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= 8'd0;
      last_hole  <= '0;
      mole       <= '0;
      score      <= 8'd0;
      misses     <= 8'd0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      last_hole  <= last_hole_d;
      mole       <= mole_d;
      score      <= score_d;
      misses     <= misses_d;
      hit_pulse  <= hit_pulse_d;
      miss_pulse <= miss_pulse_d;
    end
  end

  always_comb begin
    state_d = state;
    if (!enable) begin
      state_d = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  state_d = S_WAIT;
        S_WAIT:  if (wait_done) state_d = S_UP;
        S_UP:    if (lit_hit || up_timeout) state_d = S_WAIT;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d        = cnt;
    last_hole_d  = last_hole;
    mole_d       = mole;
    score_d      = score;
    misses_d     = misses;
    hit_pulse_d  = 1'b0;
    miss_pulse_d = 1'b0;
    if (!enable) begin
      mole_d = '0;
    end else begin
      case (state)
        S_IDLE: begin
          mole_d   = '0;
          score_d  = 8'd0;
          misses_d = 8'd0;
          cnt_d    = gap_load;
        end
        S_WAIT: begin
          mole_d = '0;
          if (wait_done) begin
            mole_d[spawn_idx] = 1'b1;
            last_hole_d       = spawn_idx;
            cnt_d             = 8'(UP_TICKS);
          end else if (tick) begin
            cnt_d = cnt - 8'd1;
          end
        end
        S_UP: begin
          // A whack on the final tick beats the timeout.
          if (lit_hit) begin
            score_d     = (score == 8'hFF) ? score : score + 8'd1;
            hit_pulse_d = 1'b1;
            mole_d      = '0;
            cnt_d       = gap_load;
          end else if (up_timeout) begin
            misses_d     = (misses == 8'hFF) ? misses : misses + 8'd1;
            miss_pulse_d = 1'b1;
            mole_d       = '0;
            cnt_d        = gap_load;
          end else if (tick) begin
            cnt_d = cnt - 8'd1;
          end
        end
        default: mole_d = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mole_spawner.sv
// tb/tb_mole_spawner.sv - directed and randomized checks of mole_spawner against a behavioural model
module tb_mole_spawner;
  localparam int NH = 8;
  localparam int GB = 2;
  localparam int UT = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tick = 1'b1;
  logic          enable = 1'b0;
  logic [7:0]    rnd = 8'h05;
  logic [NH-1:0] hit = '0;
  logic [NH-1:0] mole;
  logic [7:0]    score, misses;
  logic          hit_pulse, miss_pulse;

  int vectors = 0;
  int miscompares = 0;

  // Model: phase 0 idle, 1 gap, 2 mole up; m_left is ticks remaining in the phase.
  int            m_phase, m_left, m_last, m_score, m_miss;
  logic [NH-1:0] m_mole;
  logic          m_hp, m_mp;

  mole_spawner #(.N_HOLES(NH), .GAP_BASE(GB), .UP_TICKS(UT)) dut (
    .clk(clk), .rst(rst), .tick(tick), .enable(enable), .rnd(rnd), .hit(hit),
    .mole(mole), .score(score), .misses(misses),
    .hit_pulse(hit_pulse), .miss_pulse(miss_pulse)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_phase = 0; m_left = 0; m_last = 0; m_score = 0; m_miss = 0;
    m_mole = '0; m_hp = 1'b0; m_mp = 1'b0;
  endtask

  task automatic model_edge();
    int gap, pick;
    gap = GB + int'(rnd[7:5]);
    m_hp = 1'b0;
    m_mp = 1'b0;
    if (rst) begin
      model_reset();
    end else if (!enable) begin
      m_phase = 0;
      m_mole = '0;
    end else if (m_phase == 0) begin
      m_score = 0; m_miss = 0; m_left = gap; m_phase = 1;
    end else if (m_phase == 1) begin
      if (tick && m_left == 1) begin
        pick = int'(rnd) % NH;
        if (pick == m_last) pick = (pick + 1) % NH;
        m_last = pick;
        m_mole = NH'(1) << pick;
        m_left = UT;
        m_phase = 2;
      end else if (tick) begin
        m_left = m_left - 1;
      end
    end else begin
      if (hit[m_last]) begin
        m_score = (m_score < 255) ? m_score + 1 : 255;
        m_hp = 1'b1; m_mole = '0; m_left = gap; m_phase = 1;
      end else if (tick && m_left == 1) begin
        m_miss = (m_miss < 255) ? m_miss + 1 : 255;
        m_mp = 1'b1; m_mole = '0; m_left = gap; m_phase = 1;
      end else if (tick) begin
        m_left = m_left - 1;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic wait_mole();
    int n;
    n = 0;
    while (m_mole == '0 && n < 40) begin
      cycle();
      n++;
    end
    vectors++;
    if (m_mole == '0 || mole !== m_mole) begin
      miscompares++;
      $display("FAIL wait_mole: mole=%h expected=%h after %0d cycles", mole, m_mole, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; hit = '0; tick = 1'b1; rnd = 8'h05;
    repeat (3) cycle();
    vectors++;
    if ({mole, score, misses, hit_pulse, miss_pulse} !== '0) begin
      miscompares++;
      $display("FAIL reset: mole=%h score=%0d misses=%0d hp=%b mp=%b, required all zero",
               mole, score, misses, hit_pulse, miss_pulse);
    end
    rst = 1'b0;
    cycle();
  endtask

  task automatic test_timeout();
    enable = 1'b1;
    cycle();
    cycle();
    vectors++;
    if (mole !== 8'h00) begin miscompares++; $display("FAIL gap_hold: mole=%h required 00", mole); end
    cycle();
    vectors++;
    if (mole !== 8'h20) begin miscompares++; $display("FAIL first_spawn: mole=%h required 20", mole); end
    cycle();
    cycle();
    vectors++;
    if (mole !== 8'h20 || misses !== 8'd0) begin
      miscompares++; $display("FAIL up_window: mole=%h misses=%0d required 20/0", mole, misses);
    end
    cycle();
    vectors++;
    if (mole !== 8'h00 || misses !== 8'd1 || miss_pulse !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout: mole=%h misses=%0d mp=%b required 00/1/1", mole, misses, miss_pulse);
    end
    cycle();
    vectors++;
    if (miss_pulse !== 1'b0) begin miscompares++; $display("FAIL miss_pulse_width: mp=%b required 0", miss_pulse); end
  endtask

  task automatic test_repeat_wrap();
    wait_mole();
    vectors++;
    if (mole !== 8'h40) begin miscompares++; $display("FAIL repeat_advance: mole=%h required 40", mole); end
    repeat (3) cycle();
    rnd = 8'h07;
    wait_mole();
    vectors++;
    if (mole !== 8'h80) begin miscompares++; $display("FAIL hole7: mole=%h required 80", mole); end
    repeat (3) cycle();
    wait_mole();
    vectors++;
    if (mole !== 8'h01) begin miscompares++; $display("FAIL wrap: mole=%h required 01", mole); end
    repeat (3) cycle();
  endtask

  task automatic test_hit();
    logic [7:0] ms;
    rnd = 8'h05;
    wait_mole();
    ms = misses;
    hit = 8'h08;
    cycle();
    vectors++;
    if (mole !== 8'h20 || score !== 8'd0) begin
      miscompares++; $display("FAIL wrong_hole: mole=%h score=%0d required 20/0", mole, score);
    end
    hit = 8'h20;
    cycle();
    hit = '0;
    vectors++;
    if (score !== 8'd1 || hit_pulse !== 1'b1 || mole !== 8'h00 || misses !== ms) begin
      miscompares++;
      $display("FAIL whack: score=%0d hp=%b mole=%h misses=%0d required 1/1/00/%0d",
               score, hit_pulse, mole, misses, ms);
    end
    cycle();
    vectors++;
    if (hit_pulse !== 1'b0) begin miscompares++; $display("FAIL hit_pulse_width: hp=%b required 0", hit_pulse); end
  endtask

  task automatic test_tie();
    logic [7:0] ms;
    rnd = 8'h04;
    wait_mole();
    ms = misses;
    cycle();
    cycle();
    hit = mole;
    cycle();
    hit = '0;
    vectors++;
    if (score !== 8'd2 || hit_pulse !== 1'b1 || miss_pulse !== 1'b0 || misses !== ms) begin
      miscompares++;
      $display("FAIL tie: score=%0d hp=%b mp=%b misses=%0d required 2/1/0/%0d",
               score, hit_pulse, miss_pulse, misses, ms);
    end
    cycle();
    vectors++;
    if (hit_pulse !== 1'b0 || miss_pulse !== 1'b0) begin
      miscompares++; $display("FAIL tie_after: hp=%b mp=%b required 0/0", hit_pulse, miss_pulse);
    end
  endtask

  task automatic test_saturation();
    int want;
    enable = 1'b0; cycle();
    enable = 1'b1; cycle();
    vectors++;
    if (score !== 8'd0 || misses !== 8'd0) begin
      miscompares++; $display("FAIL restart_clear: score=%0d misses=%0d required 0/0", score, misses);
    end
    for (int i = 0; i < 256; i++) begin
      rnd = 8'($urandom);
      wait_mole();
      hit = m_mole | NH'($urandom);
      cycle();
      hit = '0;
      want = (i + 1 < 255) ? i + 1 : 255;
      vectors++;
      if (hit_pulse !== 1'b1 || score !== 8'(want)) begin
        miscompares++;
        $display("FAIL saturate[%0d]: hp=%b score=%0d required 1/%0d", i, hit_pulse, score, want);
      end
    end
    enable = 1'b0; cycle();
    enable = 1'b1; cycle();
    vectors++;
    if (score !== 8'd0 || misses !== 8'd0) begin
      miscompares++; $display("FAIL reenable_clear: score=%0d misses=%0d required 0/0", score, misses);
    end
  endtask

  task automatic test_enable_drop();
    logic [7:0] ms;
    wait_mole();
    ms = misses;
    enable = 1'b0;
    cycle();
    vectors++;
    if (mole !== 8'h00 || miss_pulse !== 1'b0) begin
      miscompares++; $display("FAIL enable_drop: mole=%h mp=%b required 00/0", mole, miss_pulse);
    end
    repeat (4) cycle();
    vectors++;
    if (misses !== ms || mole !== 8'h00) begin
      miscompares++; $display("FAIL idle_hold: misses=%0d mole=%h required %0d/00", misses, mole, ms);
    end
    enable = 1'b1;
    cycle();
  endtask

  task automatic test_async_reset();
    wait_mole();
    hit = m_mole;
    cycle();
    hit = '0;
    wait_mole();
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (mole !== 8'h00 || score !== 8'd0) begin
      miscompares++; $display("FAIL async_reset: mole=%h score=%0d required 00/0", mole, score);
    end
    model_reset();
    #1 rst = 1'b0;
    cycle();
    vectors++;
    if (mole !== 8'h00) begin miscompares++; $display("FAIL post_reset_idle: mole=%h required 00", mole); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      enable = ($urandom % 16) != 0;
      tick   = ($urandom % 3) != 0;
      rnd    = 8'($urandom);
      case ($urandom % 4)
        0: hit = '0;
        1: hit = m_mole;
        2: hit = NH'($urandom);
        default: hit = '0;
      endcase
      cycle();
      vectors++;
      if ({mole, score, misses, hit_pulse, miss_pulse} !==
          {m_mole, 8'(m_score), 8'(m_miss), m_hp, m_mp}) begin
        miscompares++;
        $display("FAIL random[%0d]: mole=%h score=%0d misses=%0d hp=%b mp=%b required %h/%0d/%0d/%b/%b",
                 i, mole, score, misses, hit_pulse, miss_pulse, m_mole, m_score, m_miss, m_hp, m_mp);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_timeout();
    test_repeat_wrap();
    test_hit();
    test_tie();
    test_saturation();
    test_enable_drop();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mole_spawner.md
Name: mole_spawner

Overview:
- Consumer of the 8-bit pseudo-random byte stream from the LFSR block.
- Uses each random byte to pick which hole lights a mole and how long the gap before the next mole lasts.
- Times the mole's up-window, detects whacks on the lit hole, and keeps saturating hit and miss tallies for the score display.
- Sits between the LFSR, the debounced button pulses, and the LED/score drivers.

Parameters:
- N_HOLES, 8, number of holes; legal values 2, 4, 8; HB = log2(N_HOLES).
- GAP_BASE, 4, minimum gap between moles in ticks; range 1..248.
- UP_TICKS, 6, ticks a mole stays up; range 1..255.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-high.
- tick  input  1  game timebase enable, one-cycle pulse; all countdowns advance only on tick.
- enable  input  1  game running; low forces IDLE.
- rnd  input  8  random byte from the LFSR, sampled combinationally when needed.
- hit  input  N_HOLES  one-cycle press pulses per hole, already debounced.
- mole  output  N_HOLES  one-hot lit hole, registered; all zero when no mole is up.
- score  output  8  hits, saturating at 255.
- misses  output  8  timeouts, saturating at 255.
- hit_pulse  output  1  one cycle high, registered, on a successful whack.
- miss_pulse  output  1  one cycle high, registered, on a mole timeout.

Behaviour:
- Reset (asynchronous, immediate): state IDLE, mole=0, score=0, misses=0, hit_pulse=0, miss_pulse=0, cnt=0, last_hole=0.
- States: IDLE, WAIT, UP. cnt is an 8-bit countdown.
- IDLE:
  - mole=0.
  - When enable=1: score and misses clear to 0, cnt loads GAP_BASE+rnd[7:5], next state WAIT. Carries out this load and the WAIT transition in the same cycle.
- WAIT:
  - On a cycle with tick=1: if cnt==1, go to UP; otherwise cnt decrements.
  - Cycles with tick=0 hold cnt.
- Entering UP:
  - idx = rnd[HB-1:0]; if idx==last_hole, use (idx+1) mod N_HOLES.
  - mole gets bit idx set, last_hole=idx, cnt=UP_TICKS.
  - mole is visible the cycle after the WAIT exit edge.
- UP, evaluated every cycle:
  - Hit: hit[last_hole]=1 on any cycle, tick not required. Result: score+1 (holds at 255), hit_pulse=1 next cycle, mole=0, cnt=GAP_BASE+rnd[7:5], go to WAIT.
  - Timeout: otherwise, tick=1 and cnt==1. Result: misses+1 (holds at 255), miss_pulse=1, mole=0, reload the gap as above, go to WAIT.
  - Otherwise: tick=1 decrements cnt.
  - Hit and timeout in the same cycle: the hit wins; no miss is counted.
  - Presses on unlit holes, or any press in IDLE/WAIT: ignored, no penalty.
  - Multiple hit bits including the lit hole count as exactly one hit.
- enable=0 in any state:
  - Next state IDLE, mole=0 next cycle.
  - No miss counted; score and misses hold until the next enable rise from IDLE.
- Pulses are low on every cycle not listed above.
- Gap in ticks is GAP_BASE+rnd[7:5], range GAP_BASE..GAP_BASE+7, no overflow given the parameter range.

Test Plan (N_HOLES=8, GAP_BASE=2, UP_TICKS=3, tick=1 every cycle, rnd held at 8'h05 unless stated):
- Reset, then enable=1 → WAIT with cnt=2; two cycles later mole=8'h20. No press → three ticks later mole=0, misses=1, miss_pulse high for one cycle.
- Continue from the previous scenario with rnd still 8'h05 → next spawn repeats hole 5, so it advances: mole=8'h40. rnd=8'h07 on a later spawn after hole 7 → mole=8'h01 (wrap).
- Mole at hole 5, hit=8'h08 → no change. Then hit=8'h20 → score=1, hit_pulse one cycle, mole=0, misses unchanged.
- hit[5] asserted in the same cycle as the third UP tick → score+1, misses unchanged, exactly one hit_pulse, no miss_pulse.
- Drive 256 successful whacks → score=255 and stays 255, hit_pulse still fires on each hit. Drop then raise enable → score=0, misses=0.
- enable=0 mid-UP → mole=0 next cycle, no miss. rst pulsed asynchronously mid-UP, between clock edges → mole=0 and state IDLE without waiting for a clk edge.
